// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to the trigger register halts the CPU and copies
// XFER_LEN bytes from page $XX00 to the OAM data port as alternating read/write bus cycles.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_cpu_rdy,
  output logic        o_bus_sel,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_wn,
  output logic [7:0]  o_dma_wdata,
  input  logic [7:0]  i_dma_rdata,
  output logic        o_busy
);

  // Index of the final byte; the counter is a full byte so the low address byte never carries.
  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } state_e;

  state_e      state_q;
  logic        parity_q;
  logic [7:0]  page_q;
  logic [7:0]  cnt_q;
  logic [7:0]  data_q;
  logic        cpu_rdy_q;
  logic        bus_sel_q;
  logic [15:0] dma_addr_q;
  logic        dma_wn_q;
  logic        busy_q;
  logic        trigger;

  // Only full-decode writes count; reads of the trigger register are ignored.
  assign trigger = (i_bus_addr == DMA_REG_ADDR) && !i_bus_wn;

  // FSM with every bus output registered so o_dma_* is stable for the whole cycle.
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state_q    <= StIdle;
      parity_q   <= 1'b0;
      page_q     <= 8'h00;
      cnt_q      <= 8'h00;
      data_q     <= 8'h00;
      cpu_rdy_q  <= 1'b1;
      bus_sel_q  <= 1'b0;
      dma_addr_q <= 16'h0000;
      dma_wn_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            page_q    <= i_bus_wdata;
            cnt_q     <= 8'h00;
            state_q   <= StHalt;
            cpu_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StHalt: begin
          // An odd HALT cycle needs one spare cycle so reads land on even cycles.
          if (parity_q) begin
            state_q <= StAlign;
          end else begin
            state_q    <= StRead;
            bus_sel_q  <= 1'b1;
            dma_addr_q <= {page_q, cnt_q};
            dma_wn_q   <= 1'b1;
          end
        end
        StAlign: begin
          state_q    <= StRead;
          bus_sel_q  <= 1'b1;
          dma_addr_q <= {page_q, cnt_q};
          dma_wn_q   <= 1'b1;
        end
        StRead: begin
          data_q     <= i_dma_rdata;
          state_q    <= StWrite;
          dma_addr_q <= OAM_DATA_ADDR;
          dma_wn_q   <= 1'b0;
        end
        StWrite: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == LastIdx) begin
            state_q   <= StIdle;
            cpu_rdy_q <= 1'b1;
            bus_sel_q <= 1'b0;
            dma_wn_q  <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            state_q    <= StRead;
            dma_addr_q <= {page_q, cnt_q + 8'd1};
            dma_wn_q   <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          cpu_rdy_q <= 1'b1;
          bus_sel_q <= 1'b0;
          dma_wn_q  <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_rdy   = cpu_rdy_q;
  assign o_bus_sel   = bus_sel_q;
  assign o_dma_addr  = dma_addr_q;
  assign o_dma_wn    = dma_wn_q;
  assign o_dma_wdata = data_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random memory image, bus monitor, OAM/OAMADDR model.
module tb_oam_dma;

  localparam int XferLen = 256;

  logic        clk;
  logic        rstn;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        cpu_rdy;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic        dma_wn;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        busy;

  oam_dma dut (
    .i_cpu_clk  (clk),
    .i_cpu_rstn (rstn),
    .i_bus_addr (bus_addr),
    .i_bus_wn   (bus_wn),
    .i_bus_wdata(bus_wdata),
    .o_cpu_rdy  (cpu_rdy),
    .o_bus_sel  (bus_sel),
    .o_dma_addr (dma_addr),
    .o_dma_wn   (dma_wn),
    .o_dma_wdata(dma_wdata),
    .i_dma_rdata(dma_rdata),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image; read data is combinational on the DMA address.
  logic [7:0] mem [0:65535];
  assign dma_rdata = mem[dma_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle count since reset release; its LSB is the parity of the current cycle.
  int cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // PPU register block model behind the downstream bus mux.
  logic [15:0] eff_addr;
  logic        eff_wn;
  logic [7:0]  eff_wdata;
  logic [7:0]  oam [0:255];
  logic [7:0]  oam_addr;
  assign eff_addr  = bus_sel ? dma_addr  : bus_addr;
  assign eff_wn    = bus_sel ? dma_wn    : bus_wn;
  assign eff_wdata = bus_sel ? dma_wdata : bus_wdata;
  always @(posedge clk) begin
    if (!eff_wn) begin
      if (eff_addr == 16'h2003) oam_addr <= eff_wdata;
      if (eff_addr == 16'h2004) begin
        oam[oam_addr] <= eff_wdata;
        oam_addr      <= oam_addr + 8'd1;
      end
    end
  end

  // Bus monitor, sampled mid-cycle.
  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];
  int rdy_low, first_rd, mon_cyc, bad_strobe;
  bit mon_en;
  initial begin
    bad_strobe = 0;
    mon_en     = 0;
  end
  always @(negedge clk) begin
    if (rstn) begin
      if (!bus_sel && !dma_wn) bad_strobe++;
      if (mon_en) begin
        if (!cpu_rdy) rdy_low++;
        if (bus_sel && dma_wn) begin
          rd_q.push_back(dma_addr);
          if (first_rd < 0) first_rd = mon_cyc;
        end
        if (bus_sel && !dma_wn) begin
          if (dma_addr == 16'h2004) wr_q.push_back(dma_wdata);
          else bad_strobe++;
        end
        mon_cyc++;
      end
    end
  end

  task automatic cpu_idle();
    bus_addr  = 16'h0000;
    bus_wn    = 1'b1;
    bus_wdata = 8'h00;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr  = a;
    bus_wn    = 1'b0;
    bus_wdata = d;
    @(posedge clk);
    #1 cpu_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rdy"},   32'(cpu_rdy),   32'h1);
    check_eq({tag, "_sel"},   32'(bus_sel),   32'h0);
    check_eq({tag, "_addr"},  32'(dma_addr),  32'h0);
    check_eq({tag, "_wn"},    32'(dma_wn),    32'h1);
    check_eq({tag, "_wdata"}, 32'(dma_wdata), 32'h0);
    check_eq({tag, "_busy"},  32'(busy),      32'h0);
  endtask

  // One DMA run. want_align picks the trigger-cycle parity; inject forces a second trigger
  // mid-transfer; abort_at>0 pulls reset after that many writes.
  task automatic run_dma(input string tag, input logic [7:0] page, input bit want_align,
                         input bit inject, input int abort_at);
    bit done;
    bit align;
    @(negedge clk);
    // Trigger-cycle parity 0 makes the HALT cycle odd, which inserts ALIGN.
    if ((cyc[0] == 1'b0) != want_align) @(negedge clk);
    align     = (cyc[0] == 1'b0);
    bus_addr  = 16'h4014;
    bus_wn    = 1'b0;
    bus_wdata = page;
    @(posedge clk);
    #1 cpu_idle();
    rd_q.delete();
    wr_q.delete();
    rdy_low  = 0;
    first_rd = -1;
    mon_cyc  = 0;
    mon_en   = 1;
    check_eq({tag, "_busy_start"}, 32'(busy), 32'h1);
    done = 0;
    for (int n = 0; n < 1100 && !done; n++) begin
      @(negedge clk);
      if (cpu_rdy) done = 1;
      if (inject && n == 50) begin
        bus_addr  = 16'h4014;
        bus_wn    = 1'b0;
        bus_wdata = page ^ 8'h5A;
      end
      if (inject && n == 51) cpu_idle();
      if (abort_at > 0 && wr_q.size() >= abort_at) begin
        #2 rstn = 1'b0;
        #1 check_reset_outputs({tag, "_async"});
        done = 1;
      end
    end
    mon_en = 0;
    if (abort_at > 0) begin
      @(negedge clk);
      rstn = 1'b1;
      return;
    end
    check_eq({tag, "_done"}, 32'(done), 32'h1);
    check_eq({tag, "_rdy_low"}, 32'(rdy_low), 32'(2 * XferLen + 1 + int'(align)));
    check_eq({tag, "_first_rd"}, 32'(first_rd), 32'(1 + int'(align)));
    check_eq({tag, "_nrd"}, 32'(rd_q.size()), 32'(XferLen));
    check_eq({tag, "_nwr"}, 32'(wr_q.size()), 32'(XferLen));
    for (int i = 0; i < XferLen; i++) begin
      if (i < rd_q.size()) check_eq({tag, "_rd_addr"}, 32'(rd_q[i]), 32'({page, 8'(i)}));
      if (i < wr_q.size()) check_eq({tag, "_wr_data"}, 32'(wr_q[i]), 32'(mem[{page, 8'(i)}]));
    end
  endtask

  initial begin
    rstn = 1'b0;
    cpu_idle();
    oam_addr = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Non-trigger accesses leave the engine idle.
    @(negedge clk);
    bus_addr = 16'h4014;
    bus_wn   = 1'b1;
    bus_wdata = 8'h02;
    @(negedge clk);
    bus_addr = 16'h4015;
    bus_wn   = 1'b0;
    @(negedge clk);
    cpu_idle();
    repeat (3) @(negedge clk);
    check_eq("nontrig_rdy", 32'(cpu_rdy), 32'h1);
    check_eq("nontrig_busy", 32'(busy), 32'h0);
    check_eq("nontrig_sel", 32'(bus_sel), 32'h0);

    // Basic copy into OAM with OAMADDR preset to $10.
    cpu_write(16'h2003, 8'h10);
    run_dma("basic", 8'h02, 1'b0, 1'b0, 0);
    for (int i = 0; i < 256; i++)
      check_eq("oam", 32'(oam[8'(8'h10 + 8'(i))]), 32'(mem[16'h0200 + i]));
    check_eq("oamaddr_end", 32'(oam_addr), 32'h10);

    run_dma("align", 8'h02, 1'b1, 1'b0, 0);
    run_dma("page_ff", 8'hFF, 1'b0, 1'b1, 0);

    // Random page, random alignment.
    run_dma("rand", 8'($urandom_range(0, 255)), 1'($urandom), 1'b0, 0);

    // Reset after 100 writes, then a clean restart from byte 0.
    run_dma("abort", 8'h03, 1'b0, 1'b0, 100);
    check_reset_outputs("post_abort");
    run_dma("restart", 8'h03, 1'b1, 1'b0, 0);

    check_eq("bad_strobe", 32'(bad_strobe), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
